// File: rtl/chase_checker.sv
// chase_checker: passive monitor that learns a one-hot walking-light pattern
// (direction and step rate), locks onto it and flags every departure.
module chase_checker #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned LOCK_STEPS  = 3,
    parameter int unsigned ERR_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         l,
    output logic                     locked,
    output logic                     dir,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     err_pulse,
    output logic [ERR_W-1:0]         err_count
);

    localparam int unsigned POS_W   = $clog2(WIDTH);
    localparam int unsigned DWELL_W = $clog2(STEP_CYCLES + 1);
    localparam int unsigned STEP_W  = $clog2(LOCK_STEPS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic               have_q, have_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               dir_q, dir_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic               valid_c;
    logic [POS_W-1:0]   l_idx_c;
    logic [WIDTH-1:0]   rot_up_c, rot_dn_c, next_c;
    logic               same_c, dwell_full_c, locked_ok_c, violation_c;
    logic               acq_step_c, acq_hold_c, lock_hit_c, seed_c;

    // Index of the lit lamp; only meaningful when the sample is one-hot.
    always_comb begin
        l_idx_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (l[i]) l_idx_c = POS_W'(i);
        end
    end

    // Sample classification against the captured value and learned direction.
    always_comb begin
        valid_c      = $onehot(l);
        rot_up_c     = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
        rot_dn_c     = {cur_q[0], cur_q[WIDTH-1:1]};
        next_c       = dir_q ? rot_up_c : rot_dn_c;
        same_c       = (l == cur_q);
        dwell_full_c = (dwell_q == DWELL_W'(STEP_CYCLES));
        locked_ok_c  = dwell_full_c ? (l == next_c) : same_c;
        violation_c  = (state_q == ST_LOCKED) && !locked_ok_c;
        acq_hold_c   = have_q && same_c && !dwell_full_c;
        acq_step_c   = have_q && valid_c && !same_c &&
                       (((step_q == '0) && ((l == rot_up_c) || (l == rot_dn_c))) ||
                        ((step_q != '0) && (l == next_c) && dwell_full_c));
        lock_hit_c   = acq_step_c && ((32'(step_q) + 32'd1) == LOCK_STEPS);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; a disabled monitor always parks in IDLE.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACQ: state_d = lock_hit_c ? ST_LOCKED : ST_ACQ;
                ST_LOCKED:       if (violation_c) state_d = ST_ACQ;
                default:         state_d = ST_IDLE;
            endcase
        end
    end

    // Tracking datapath and output next values; IDLE acts as an empty ACQUIRE.
    always_comb begin
        cur_d       = cur_q;
        have_d      = have_q;
        dwell_d     = dwell_q;
        step_d      = step_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        seed_c      = 1'b0;
        if (!enable) begin
            have_d   = 1'b0;
            dwell_d  = '0;
            step_d   = '0;
            locked_d = 1'b0;
        end else if (state_q == ST_LOCKED) begin
            if (violation_c) begin
                err_pulse_d = 1'b1;
                if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                locked_d = 1'b0;
                seed_c   = 1'b1;
            end else if (same_c) begin
                dwell_d = dwell_q + DWELL_W'(1);
            end else begin
                cur_d   = l;
                dwell_d = DWELL_W'(1);
                pos_d   = l_idx_c;
            end
        end else begin
            if (acq_hold_c) begin
                dwell_d = dwell_q + DWELL_W'(1);
            end else if (acq_step_c) begin
                cur_d   = l;
                dwell_d = DWELL_W'(1);
                pos_d   = l_idx_c;
                step_d  = step_q + STEP_W'(1);
                if (step_q == '0) dir_d = (l == rot_up_c);
                if (lock_hit_c)   locked_d = 1'b1;
            end else begin
                seed_c = 1'b1;
            end
        end
        // Restart acquisition from this sample, or wait if it is not one-hot.
        if (seed_c) begin
            step_d = '0;
            have_d = valid_c;
            if (valid_c) begin
                cur_d   = l;
                dwell_d = DWELL_W'(1);
                pos_d   = l_idx_c;
            end else begin
                dwell_d = '0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q       <= '0;
            have_q      <= 1'b0;
            dwell_q     <= '0;
            step_q      <= '0;
            dir_q       <= 1'b0;
            pos_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            cur_q       <= cur_d;
            have_q      <= have_d;
            dwell_q     <= dwell_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign dir       = dir_q;
    assign pos       = pos_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: doc/chase_checker.md
# chase_checker

Passive monitor for the LightChaser output bus. It samples the chaser's one-hot lamp vector every clock, learns its direction and step rate, then locks and flags every cycle where the vector leaves the legal walking-light sequence. It sits beside the `lighter` instance, either in the bench or as an on-chip self-check, and never drives the lamps.

## Interface
- `WIDTH`, 5: number of lamps (≥2).
- `STEP_CYCLES`, 1: clock edges each lamp position is held by the chaser (≥1).
- `LOCK_STEPS`, 3: consecutive legal transitions required to declare lock (≥1).
- `ERR_W`, 8: error counter width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  monitor enable; mirrors the chaser's enable.
- `l`  in  WIDTH  lamp vector under observation.
- `locked`  out  1  sequence tracked and consistent.
- `dir`  out  1  1 = walking up (bit i → i+1), 0 = walking down.
- `pos`  out  $clog2(WIDTH)  index of lit lamp in last valid sample.
- `err_pulse`  out  1  one-cycle strobe per detected violation (LOCKED only).
- `err_count`  out  ERR_W  violations since reset, saturating at all-ones.

## Operation
- Valid sample: exactly one bit of `l` set. Zero or multiple bits are invalid.
- Legal step: new one-hot value is the current value rotated by one position in `dir`, wrapping bit WIDTH-1 ↔ bit 0.
- Dwell counter: set to 1 when a new value is captured, +1 on each edge where `l` is unchanged.
- States:
  - IDLE: entered on reset or whenever `enable`=0. `locked`=0, `err_count` holds. `enable`=1 → ACQUIRE.
  - ACQUIRE: first valid sample is captured (dwell=1, step count 0). First change to a ±1 rotation sets `dir` and counts step 1, without a dwell check (the first hold may be partial). Each later change must be a legal step in `dir` and occur with dwell == STEP_CYCLES. Any invalid sample, illegal step, wrong dwell, or hold beyond STEP_CYCLES restarts acquisition: capture the sample if valid, otherwise wait. No error is counted. At step count == LOCK_STEPS → LOCKED.
  - LOCKED: while dwell < STEP_CYCLES, `l` must equal the current value. At dwell == STEP_CYCLES, `l` must be the next legal step. A mismatch raises `err_pulse`, increments `err_count` (saturating), clears `locked` and moves to ACQUIRE. The offending sample seeds acquisition if it is valid.
- `pos` updates on every captured valid sample, in any state.
- Priority on a single edge: `reset` > `enable`=0 > violation check. `enable` falling on the same edge as a mismatch counts no error.

## Timing
- Reset values: `locked`=0, `dir`=0, `pos`=0, `err_pulse`=0, `err_count`=0. State IDLE, dwell and step counters 0.
- All outputs are registered. The effect of a sample taken at edge N is visible after edge N, with no combinational path from `l` to outputs.
- Lock latency: with the first valid sample at edge N and a clean sequence, `locked` rises after edge N + LOCK_STEPS·STEP_CYCLES. Example: STEP_CYCLES=1, LOCK_STEPS=3 gives lock 3 edges after the first sample.
- Stall detection: a value still present at the edge where dwell == STEP_CYCLES is a violation at that edge.
- `err_pulse` is high for exactly one cycle per violation. Back-to-back violations cannot occur, because ACQUIRE never reports.
- `reset` asserted mid-operation returns every output to its reset value after the next edge.

## Test plan
Unless stated otherwise: WIDTH=5, STEP_CYCLES=1, LOCK_STEPS=3.

1. `reset`=1 for 5 cycles with `enable`=0, `l`=00000 → all outputs 0. Then `enable`=0 with `l` toggling → outputs stay 0.
2. `enable`=1, `l`=00001,00010,00100,01000,10000,00001 on consecutive edges → `locked`=1 after the 01000 edge, `dir`=1. `pos` runs 0,1,2,3,4,0 through the wrap, `err_count`=0.
3. Down walk `l`=10000,01000,00100,00010,00001,10000 → lock with `dir`=0, wrap 00001→10000 accepted, no errors.
4. Locked up at 00100, drive 00101 then 00100,01000,10000,00001 → `err_pulse` for one cycle, `err_count`=1, `locked`=0. Relock after 01000,10000,00001 with `pos`=0.
5. STEP_CYCLES=2, each value held 2 edges → lock. Then hold 01000 for 3 edges → error at the third edge. Separately, advance after 1 edge → error.
6. ERR_W=2: cause 4 violations → `err_pulse` fires 4 times and `err_count` stops at 3. Assert `reset` while locked → `locked`=0, `err_count`=0 one edge later. Drop `enable` on a mismatch edge → no increment.
